// File: rtl/cmsdk_ahb_arb_pkg.sv
// cmsdk_ahb_arb_pkg
// Shared encodings and the address-phase control payload for the two-port
// AHB-Lite arbiter (cmsdk_ahb_arb2) and its per-port hold register.
// Optional feature macro used by importers: ARM_CMSDK_AHB_ARB_BURST_HOLD_EN.
package cmsdk_ahb_arb_pkg;

    // Data bus width of every port.
    localparam int unsigned DW      = 32;
    // Width of the data-phase owner code.
    localparam int unsigned OWNER_W = 2;

    // HTRANS encodings.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings.
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Data-phase owner codes; OWNER_NONE means no transfer is in its data phase.
    localparam logic [OWNER_W-1:0] OWNER_M0   = 2'b00;
    localparam logic [OWNER_W-1:0] OWNER_M1   = 2'b01;
    localparam logic [OWNER_W-1:0] OWNER_NONE = 2'b10;

    // Address-phase control fields carried alongside the address.
    typedef struct packed {
        logic [1:0] trans;
        logic [2:0] size;
        logic       write;
    } ahb_ctrl_t;

endpackage : cmsdk_ahb_arb_pkg

// File: rtl/cmsdk_ahb_arb_holdreg.sv
// cmsdk_ahb_arb_holdreg
// One slave port's capture register and stall logic. A live request that the
// port was told is accepted (ready high) but that the shared bus did not take
// is parked here; the port is then stalled until the parked transfer has had
// its address phase accepted downstream.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   s_addr, s_ctrl  address and control presented by the port
//   s_ready         port-side HREADY
//   data_own        this port owns the current data phase
//   hreadym         downstream HREADY
//   grant_c         this port drives the shared address phase this cycle
//   cand_c          port has a transfer to offer (held or live)
//   src_addr_c      address to offer (held copy has priority)
//   src_ctrl_c      control to offer (held copy has priority)
//   hready_out_c    ready returned to the port
module cmsdk_ahb_arb_holdreg
    import cmsdk_ahb_arb_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] s_addr,
    input  ahb_ctrl_t     s_ctrl,
    input  logic          s_ready,
    input  logic          data_own,
    input  logic          hreadym,
    input  logic          grant_c,
    output logic          cand_c,
    output logic [AW-1:0] src_addr_c,
    output ahb_ctrl_t     src_ctrl_c,
    output logic          hready_out_c
);

    logic          hold_valid;
    logic [AW-1:0] hold_addr;
    ahb_ctrl_t     hold_ctrl;

    logic live_c;
    logic accept_c;
    logic capture_c;

    // IDLE and BUSY never count as requests; nothing is live while in reset.
    assign live_c = rst_n & s_ready &
                    (s_ctrl.trans != HTRANS_IDLE) &
                    (s_ctrl.trans != HTRANS_BUSY);

    assign accept_c = grant_c & hreadym;

    // Stall while a parked transfer is pending; otherwise the data-phase owner
    // follows the downstream ready and everyone else sees ready.
    always_comb begin
        hready_out_c = 1'b1;
        if (hold_valid) begin
            hready_out_c = 1'b0;
        end else if (data_own) begin
            hready_out_c = hreadym;
        end
    end

    // Park a request the port believes was taken but the bus did not accept.
    // A port stalled as data-phase owner keeps its request itself.
    assign capture_c = live_c & ~accept_c & hready_out_c;

    assign cand_c     = rst_n & (hold_valid | live_c);
    assign src_addr_c = hold_valid ? hold_addr : s_addr;
    assign src_ctrl_c = hold_valid ? hold_ctrl : s_ctrl;

    // Capture register; capture and clear are mutually exclusive because
    // capture needs ready high, which implies the register is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_ctrl  <= '0;
        end else if (capture_c) begin
            hold_valid <= 1'b1;
            hold_addr  <= s_addr;
            hold_ctrl  <= s_ctrl;
        end else if (hold_valid && accept_c) begin
            hold_valid <= 1'b0;
        end
    end

endmodule : cmsdk_ahb_arb_holdreg

// File: rtl/cmsdk_ahb_arb2.sv
// cmsdk_ahb_arb2
// Two-port AHB-Lite arbiter: slave port 0 (CPU) and slave port 1 (DMA) share
// one downstream AHB-Lite master port. Uncontended owner requests pass through
// with no added latency; a losing request is parked in its port's hold
// register and the port is stalled until the parked transfer is issued.
// Arbitration is round-robin and happens only while HREADYM is high.
//
// Build option: define ARM_CMSDK_AHB_ARB_BURST_HOLD_EN to let an owner that
// presents SEQ keep the bus for the rest of its burst.
//
// Ports:
//   HCLK, HRESETn                      clock, synchronous active-low reset
//   HADDRSx/HTRANSSx/HSIZESx/HWRITESx  address phase from port x
//   HWDATASx, HREADYSx                 write data and port-side HREADY
//   HREADYOUTSx/HRESPSx/HRDATASx       response back to port x
//   HADDRM/HTRANSM/HSIZEM/HWRITEM      shared downstream address phase
//   HWDATAM                            write data of the data-phase owner
//   HREADYM/HRESPM/HRDATAM             downstream response
//   HMASTERM                           current address-phase owner index
module cmsdk_ahb_arb2
    import cmsdk_ahb_arb_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned PARK_M = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] HADDRS0,
    input  logic [1:0]    HTRANSS0,
    input  logic [2:0]    HSIZES0,
    input  logic          HWRITES0,
    input  logic [DW-1:0] HWDATAS0,
    input  logic          HREADYS0,
    output logic          HREADYOUTS0,
    output logic          HRESPS0,
    output logic [DW-1:0] HRDATAS0,
    input  logic [AW-1:0] HADDRS1,
    input  logic [1:0]    HTRANSS1,
    input  logic [2:0]    HSIZES1,
    input  logic          HWRITES1,
    input  logic [DW-1:0] HWDATAS1,
    input  logic          HREADYS1,
    output logic          HREADYOUTS1,
    output logic          HRESPS1,
    output logic [DW-1:0] HRDATAS1,
    output logic [AW-1:0] HADDRM,
    output logic [1:0]    HTRANSM,
    output logic [2:0]    HSIZEM,
    output logic          HWRITEM,
    output logic [DW-1:0] HWDATAM,
    input  logic          HREADYM,
    input  logic          HRESPM,
    input  logic [DW-1:0] HRDATAM,
    output logic          HMASTERM
);

    localparam logic PARK_IDX = 1'(PARK_M);

    // Address-phase owner (also the most recent grant) and data-phase owner.
    logic               owner_q;
    logic [OWNER_W-1:0] downer_q;

    ahb_ctrl_t     ctrl0_c;
    ahb_ctrl_t     ctrl1_c;
    logic [1:0]    cand_c;
    logic [AW-1:0] src_addr_c [2];
    ahb_ctrl_t     src_ctrl_c [2];
    logic [1:0]    hready_out_c;
    logic [1:0]    port_grant_c;

    logic          grant_c;
    logic          keep_c;
    logic          issue_c;
    logic          switch_c;
    ahb_ctrl_t     sel_ctrl_c;
    logic [AW-1:0] sel_addr_c;
    logic [1:0]    trans_c;

    assign ctrl0_c = '{trans: HTRANSS0, size: HSIZES0, write: HWRITES0};
    assign ctrl1_c = '{trans: HTRANSS1, size: HSIZES1, write: HWRITES1};

    // Per-port capture registers and stall logic.
    cmsdk_ahb_arb_holdreg #(.AW(AW)) u_hold0 (
        .clk          (HCLK),
        .rst_n        (HRESETn),
        .s_addr       (HADDRS0),
        .s_ctrl       (ctrl0_c),
        .s_ready      (HREADYS0),
        .data_own     (downer_q == OWNER_M0),
        .hreadym      (HREADYM),
        .grant_c      (port_grant_c[0]),
        .cand_c       (cand_c[0]),
        .src_addr_c   (src_addr_c[0]),
        .src_ctrl_c   (src_ctrl_c[0]),
        .hready_out_c (hready_out_c[0])
    );

    cmsdk_ahb_arb_holdreg #(.AW(AW)) u_hold1 (
        .clk          (HCLK),
        .rst_n        (HRESETn),
        .s_addr       (HADDRS1),
        .s_ctrl       (ctrl1_c),
        .s_ready      (HREADYS1),
        .data_own     (downer_q == OWNER_M1),
        .hreadym      (HREADYM),
        .grant_c      (port_grant_c[1]),
        .cand_c       (cand_c[1]),
        .src_addr_c   (src_addr_c[1]),
        .src_ctrl_c   (src_ctrl_c[1]),
        .hready_out_c (hready_out_c[1])
    );

    // Owner keeps the bus mid-burst only when burst hold is built in.
    always_comb begin
        keep_c = 1'b0;
`ifdef ARM_CMSDK_AHB_ARB_BURST_HOLD_EN
        keep_c = cand_c[owner_q] & (src_ctrl_c[owner_q].trans == HTRANS_SEQ);
`endif
    end

    // Round-robin grant; ownership is frozen while the downstream is waited.
    always_comb begin
        grant_c = owner_q;
        if (HREADYM) begin
            unique case (cand_c)
                2'b01:   grant_c = 1'b0;
                2'b10:   grant_c = 1'b1;
                2'b11:   grant_c = keep_c ? owner_q : ~owner_q;
                default: grant_c = owner_q;
            endcase
        end
    end

    assign issue_c      = cand_c[grant_c];
    assign switch_c     = grant_c != owner_q;
    assign sel_addr_c   = src_addr_c[grant_c];
    assign sel_ctrl_c   = src_ctrl_c[grant_c];
    assign port_grant_c = {issue_c & grant_c, issue_c & ~grant_c};

    // Shared address phase; a SEQ following a change of owner becomes NONSEQ
    // because the downstream slave never saw the start of that burst.
    always_comb begin
        trans_c = HTRANS_IDLE;
        HADDRM  = '0;
        HSIZEM  = '0;
        HWRITEM = 1'b0;
        if (issue_c) begin
            trans_c = (switch_c && (sel_ctrl_c.trans == HTRANS_SEQ)) ?
                      HTRANS_NONSEQ : sel_ctrl_c.trans;
            HADDRM  = sel_addr_c;
            HSIZEM  = sel_ctrl_c.size;
            HWRITEM = sel_ctrl_c.write;
        end
    end

    assign HTRANSM  = trans_c;
    assign HMASTERM = grant_c;

    // Ownership advances only on accepted address phases.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            owner_q  <= PARK_IDX;
            downer_q <= OWNER_NONE;
        end else if (HREADYM) begin
            owner_q  <= grant_c;
            downer_q <= trans_c[1] ? {1'b0, grant_c} : OWNER_NONE;
        end
    end

    // Write data follows the data-phase owner.
    always_comb begin
        unique case (downer_q)
            OWNER_M0: HWDATAM = HWDATAS0;
            OWNER_M1: HWDATAM = HWDATAS1;
            default:  HWDATAM = '0;
        endcase
    end

    // Responses: the data-phase owner sees the downstream response, the other
    // port sees OKAY (both cycles of an ERROR go to the owner only).
    always_comb begin
        HRESPS0 = HRESP_OKAY;
        HRESPS1 = HRESP_OKAY;
        if (HRESPM == HRESP_ERROR) begin
            HRESPS0 = (downer_q == OWNER_M0) ? HRESP_ERROR : HRESP_OKAY;
            HRESPS1 = (downer_q == OWNER_M1) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    assign HREADYOUTS0 = hready_out_c[0];
    assign HREADYOUTS1 = hready_out_c[1];
    assign HRDATAS0    = HRDATAM;
    assign HRDATAS1    = HRDATAM;

endmodule : cmsdk_ahb_arb2

// File: tb/tb_cmsdk_ahb_arb2.sv
// tb_cmsdk_ahb_arb2
// Randomized two-master / one-slave traffic against a transfer-level model of
// the arbiter. Each port's master stalls on its own HREADY; the model tracks,
// per port, a transfer the master believes was taken but the bus still owes,
// plus the last grant and the data-phase owner.
module tb_cmsdk_ahb_arb2;

    localparam int unsigned AW   = 32;
    localparam int unsigned NCYC = 4000;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [AW-1:0] HADDRS0, HADDRS1, HADDRM;
    logic [1:0]    HTRANSS0, HTRANSS1, HTRANSM;
    logic [2:0]    HSIZES0, HSIZES1, HSIZEM;
    logic          HWRITES0, HWRITES1, HWRITEM;
    logic [31:0]   HWDATAS0, HWDATAS1, HWDATAM;
    logic          HREADYS0, HREADYS1;
    logic          HREADYOUTS0, HREADYOUTS1;
    logic          HRESPS0, HRESPS1;
    logic [31:0]   HRDATAS0, HRDATAS1;
    logic          HREADYM, HRESPM;
    logic [31:0]   HRDATAM;
    logic          HMASTERM;

    always #5 HCLK = ~HCLK;

    // Master-side state (address phase being presented, write data of the
    // transfer in its data phase).
    logic [31:0] m_addr  [2];
    logic [1:0]  m_trans [2];
    logic [2:0]  m_size  [2];
    logic        m_write [2];
    logic [31:0] m_wdata [2];

    assign HADDRS0  = m_addr[0];
    assign HTRANSS0 = m_trans[0];
    assign HSIZES0  = m_size[0];
    assign HWRITES0 = m_write[0];
    assign HWDATAS0 = m_wdata[0];
    assign HADDRS1  = m_addr[1];
    assign HTRANSS1 = m_trans[1];
    assign HSIZES1  = m_size[1];
    assign HWRITES1 = m_write[1];
    assign HWDATAS1 = m_wdata[1];

    // Each master is wired to its own ready.
    assign HREADYS0 = HREADYOUTS0;
    assign HREADYS1 = HREADYOUTS1;

    cmsdk_ahb_arb2 #(.AW(AW), .PARK_M(0)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDRS0     (HADDRS0),
        .HTRANSS0    (HTRANSS0),
        .HSIZES0     (HSIZES0),
        .HWRITES0    (HWRITES0),
        .HWDATAS0    (HWDATAS0),
        .HREADYS0    (HREADYS0),
        .HREADYOUTS0 (HREADYOUTS0),
        .HRESPS0     (HRESPS0),
        .HRDATAS0    (HRDATAS0),
        .HADDRS1     (HADDRS1),
        .HTRANSS1    (HTRANSS1),
        .HSIZES1     (HSIZES1),
        .HWRITES1    (HWRITES1),
        .HWDATAS1    (HWDATAS1),
        .HREADYS1    (HREADYS1),
        .HREADYOUTS1 (HREADYOUTS1),
        .HRESPS1     (HRESPS1),
        .HRDATAS1    (HRDATAS1),
        .HADDRM      (HADDRM),
        .HTRANSM     (HTRANSM),
        .HSIZEM      (HSIZEM),
        .HWRITEM     (HWRITEM),
        .HWDATAM     (HWDATAM),
        .HREADYM     (HREADYM),
        .HRESPM      (HRESPM),
        .HRDATAM     (HRDATAM),
        .HMASTERM    (HMASTERM)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    typedef struct {
        bit          v;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic        wr;
    } xfer_t;

    // Model state.
    xfer_t owed [2];
    xfer_t req  [2];
    logic  rdy  [2];
    int    last;
    int    dph;
    int    win;
    bit    issue;
    logic [1:0]  exp_trans;
    logic [31:0] exp_wdata;

    // Next-cycle master values, applied after the clock edge.
    logic [31:0] n_addr  [2];
    logic [1:0]  n_trans [2];
    logic [2:0]  n_size  [2];
    logic        n_write [2];
    logic [31:0] n_wdata [2];
    logic        seen_rdy [2];

    int   rst_left;
    logic rst_edge;
    int   err_state;
    int   r;

    task automatic model_reset();
        for (int x = 0; x < 2; x++) owed[x].v = 1'b0;
        last = 0;
        dph  = -1;
    endtask

    initial begin
        HRESETn   = 1'b0;
        HREADYM   = 1'b1;
        HRESPM    = 1'b0;
        HRDATAM   = '0;
        err_state = 0;
        rst_left  = 2;
        for (int x = 0; x < 2; x++) begin
            m_addr[x] = '0; m_trans[x] = 2'b00; m_size[x] = '0;
            m_write[x] = 1'b0; m_wdata[x] = '0;
            n_addr[x] = '0; n_trans[x] = 2'b00; n_size[x] = '0;
            n_write[x] = 1'b0; n_wdata[x] = '0;
        end
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge HCLK);
            #1;
            rst_edge = HRESETn;
            for (int x = 0; x < 2; x++) begin
                m_addr[x] = n_addr[x]; m_trans[x] = n_trans[x]; m_size[x] = n_size[x];
                m_write[x] = n_write[x]; m_wdata[x] = n_wdata[x];
            end

            // Reset injection: two low cycles, the second is checked.
            if (rst_left == 0 && (cyc == NCYC / 2 || $urandom_range(0, 599) == 0))
                rst_left = 2;
            HRESETn = (rst_left == 0);
            if (rst_left > 0) rst_left--;

            // Downstream slave: random waits and two-cycle ERROR responses.
            HRDATAM = 32'($urandom);
            if (err_state == 1) begin
                HREADYM = 1'b1; HRESPM = 1'b1; err_state = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                HREADYM = 1'b0; HRESPM = 1'b1; err_state = 1;
            end else begin
                HREADYM = ($urandom_range(0, 3) != 0);
                HRESPM  = 1'b0;
            end

            #5;
            if (!HRESETn) begin
                if (!rst_edge) begin
                    check("rst_htrans",  64'(HTRANSM), 64'(2'b00));
                    check("rst_haddr",   64'(HADDRM), 64'(0));
                    check("rst_hsize",   64'(HSIZEM), 64'(0));
                    check("rst_hwrite",  64'(HWRITEM), 64'(0));
                    check("rst_hmaster", 64'(HMASTERM), 64'(0));
                    check("rst_rdy0",    64'(HREADYOUTS0), 64'(1));
                    check("rst_rdy1",    64'(HREADYOUTS1), 64'(1));
                    check("rst_resp0",   64'(HRESPS0), 64'(0));
                    check("rst_resp1",   64'(HRESPS1), 64'(0));
                end
                model_reset();
            end else begin
                // What each port is told, and what each port offers.
                for (int x = 0; x < 2; x++) begin
                    rdy[x] = owed[x].v ? 1'b0 : ((dph == x) ? HREADYM : 1'b1);
                    if (owed[x].v) begin
                        req[x] = owed[x];
                    end else begin
                        req[x].v     = m_trans[x][1] && rdy[x];
                        req[x].addr  = m_addr[x];
                        req[x].trans = m_trans[x];
                        req[x].size  = m_size[x];
                        req[x].wr    = m_write[x];
                    end
                end

                if (!HREADYM || (!req[0].v && !req[1].v)) win = last;
                else if (req[0].v && !req[1].v)           win = 0;
                else if (!req[0].v)                       win = 1;
                else begin
                    win = 1 - last;
`ifdef ARM_CMSDK_AHB_ARB_BURST_HOLD_EN
                    if (req[last].trans == 2'b11) win = last;
`endif
                end
                issue = req[win].v;
                exp_trans = 2'b00;
                if (issue)
                    exp_trans = (win != last && req[win].trans == 2'b11) ? 2'b10 : req[win].trans;
                exp_wdata = (dph == 0) ? m_wdata[0] : (dph == 1) ? m_wdata[1] : 32'h0;

                check("htrans",  64'(HTRANSM), 64'(exp_trans));
                check("hmaster", 64'(HMASTERM), 64'(win));
                if (issue) begin
                    check("haddr",  64'(HADDRM), 64'(req[win].addr));
                    check("hsize",  64'(HSIZEM), 64'(req[win].size));
                    check("hwrite", 64'(HWRITEM), 64'(req[win].wr));
                end
                check("rdy0",   64'(HREADYOUTS0), 64'(rdy[0]));
                check("rdy1",   64'(HREADYOUTS1), 64'(rdy[1]));
                check("resp0",  64'(HRESPS0), 64'((dph == 0) ? HRESPM : 1'b0));
                check("resp1",  64'(HRESPS1), 64'((dph == 1) ? HRESPM : 1'b0));
                check("hwdata", 64'(HWDATAM), 64'(exp_wdata));
                check("rdata0", 64'(HRDATAS0), 64'(HRDATAM));
                check("rdata1", 64'(HRDATAS1), 64'(HRDATAM));

                // Advance the model across the coming edge.
                for (int x = 0; x < 2; x++) begin
                    if (issue && win == x && HREADYM) owed[x].v = 1'b0;
                    else if (!owed[x].v && req[x].v)  owed[x] = req[x];
                end
                if (HREADYM) begin
                    last = win;
                    dph  = issue ? win : -1;
                end
            end

            // Masters move on when their ready is high at the edge.
            seen_rdy[0] = HREADYS0;
            seen_rdy[1] = HREADYS1;
            for (int x = 0; x < 2; x++) begin
                if (seen_rdy[x]) begin
                    if (m_trans[x][1]) n_wdata[x] = 32'($urandom);
                    r = $urandom_range(0, 99);
                    n_trans[x] = (r < 30) ? 2'b00 : (r < 40) ? 2'b01 : (r < 75) ? 2'b10 : 2'b11;
                    n_addr[x]  = (n_trans[x] == 2'b11) ? m_addr[x] + 32'd4
                                                       : (32'($urandom) & 32'hFFFF_FFFC);
                    n_size[x]  = 3'($urandom_range(0, 2));
                    n_write[x] = 1'($urandom_range(0, 1));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_cmsdk_ahb_arb2
